mux_rr_arb: RTL and testbench
=============================

Name: mux_rr_arb

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes:
  - Direct select: the channel is chosen by the sel input, as with the earlier combinational 4:1 mux.
  - Round-robin: the channel is chosen by a fair arbiter with a rotating priority pointer.
- Has a one-entry output register, giving 1-cycle latency and full throughput.
- Sits between several producers and one consumer, e.g. sharing one datapath among several sources.

Parameters:
- W, 4, data width per channel (W >= 1).
- N, 4, number of input channels (N >= 2; need not be a power of 2).
- SW, $clog2(N), width of the select, pointer and source-index fields (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit is high in any cycle.
- mode  input  1  0 = direct select (MODE_SEL), 1 = round-robin (MODE_RR).
- sel  input  SW  channel index used in MODE_SEL; ignored in MODE_RR.
- out_data  output  W  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_src  output  SW  index of the channel that produced the current out_data.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0, out_data=0, out_src=0, rr pointer ptr=0.
  - in_ready is forced to all-zero combinationally while rst is high.
- Output stage can load: can_load = !out_valid || out_ready.
- Grant, MODE_SEL:
  - g=sel; gnt_v = in_valid[sel].
  - sel >= N gives gnt_v=0: no channel is granted and nothing is accepted.
- Grant, MODE_RR:
  - g = first channel with in_valid set, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - gnt_v = |in_valid.
- in_ready[i] = !rst && gnt_v && can_load && (i==g). Ready depends combinationally on valid; producers must not make valid depend on ready.
- Transfer on input g:
  - Occurs when in_valid[g] && in_ready[g].
  - Next edge: out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - Latency is exactly 1 cycle.
- Output consumed with no new transfer (out_valid && out_ready && no transfer): out_valid <= 0.
- Simultaneous drain and load (out_ready=1 and a transfer in the same cycle): the register is replaced. This gives back-to-back throughput of 1 word per cycle with no bubble.
- Back-pressure (out_valid && !out_ready): out_data and out_src hold stable, and all in_ready are 0.
- Pointer:
  - Updates only on a transfer while mode==MODE_RR: ptr <= (g==N-1) ? 0 : g+1.
  - Unchanged in MODE_SEL and on cycles without a transfer.
  - Wrap-around from N-1 to 0 must work for non-power-of-2 N.
- Mode switch: takes effect in the same cycle it changes (purely combinational selection). ptr is retained across the switch. In-flight output data is unaffected.
- Reset mid-operation: pending output data is discarded (out_valid=0). Any word presented that cycle is not accepted.
- Single requester in MODE_RR: that channel is granted every cycle regardless of ptr.

Decomposition:
- Shared package/header mux_pkg holds MODE_SEL=1'b0 and MODE_RR=1'b1 and a clog2 helper if the toolflow lacks $clog2.
- One sub-module, rr_arbiter (parameter N):
  - Inputs: clk, rst, req[N], advance, en.
  - Outputs: gnt_idx[SW], gnt_v.
  - Owns ptr and the rotate/priority scan.
- The top level adds the sel path, the mode mux, the handshake logic and the output register.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with in_valid=4'b1111.
  - Required: out_valid=0, out_data=0, out_src=0, in_ready=0.
  - After release, the first transfer in RR mode comes from channel 0.
- MODE_SEL sweep:
  - Stimulus: in_data channels 0..3 = 4'h1, 4'h2, 4'h4, 4'h8; all valid; out_ready=1; sel stepped 0..3 one per cycle.
  - Required: out_data = 1, 2, 4, 8 one cycle after each sel, with out_src matching sel.
- MODE_RR fairness:
  - Stimulus: all four valid, out_ready=1, 8 cycles.
  - Required: out_src sequence 0,1,2,3,0,1,2,3; each in_ready one-hot in turn.
- Sparse RR with wrap:
  - Stimulus: ptr=3 (after a channel-2 transfer), in_valid=4'b0011.
  - Required: grant goes to channel 0, then channel 1, then channel 0.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1 and out_data=4'h4.
  - Required during stall: out_data stays 4'h4 and in_ready=0.
  - On out_ready=1, the next word loads in the same edge with no bubble.
- Edge cases:
  - Stimulus: N=3 instance, sel=2'd3 in MODE_SEL; separately, rst asserted while out_valid=1.
  - Required: no transfer and in_ready=0 for sel=3; out_valid=0 on the edge after rst.

Source files
------------

// File: rtl/mux_rr_arb_pkg.sv
// Shared types for the registered N:1 handshake mux.
// Mode encoding for direct-select vs round-robin arbitration.
package mux_rr_arb_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_rr_arb_if.sv
// Handshake bundle: N producer channels in, one consumer out.
// slave = mux side, master = producer/consumer side.
interface mux_rr_arb_if #(
  parameter int W = 4,
  parameter int N = 4
) ();

  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_src;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

endinterface

// File: rtl/mux_rr_arb_rr_arbiter.sv
// Round-robin arbiter with rotating priority pointer.
// Ports: clk, rst, req, advance, en -> gnt_idx, gnt_v.
module mux_rr_arb_rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic          en,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_v
);

  logic [SW-1:0] r_ptr;
  logic [SW:0]   w_c;
  logic          w_found;

  // scan ptr, ptr+1, ... wrapping at N (N need not be 2^k)
  always_comb begin
    gnt_idx = '0;
    w_found = 1'b0;
    w_c     = '0;
    for (int k = 0; k < N; k++) begin
      w_c = {1'b0, r_ptr} + (SW+1)'(k);
      if (w_c >= (SW+1)'(N))
        w_c = w_c - (SW+1)'(N);
      if (!w_found && req[w_c[SW-1:0]]) begin
        w_found = 1'b1;
        gnt_idx = w_c[SW-1:0];
      end
    end
  end

  assign gnt_v = |req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && en) begin
      if (gnt_idx == SW'(N-1))
        r_ptr <= '0;
      else
        r_ptr <= gnt_idx + SW'(1);
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// Registered N:1 valid/ready mux, direct-select or round-robin.
// Ports: clk, rst, mode, sel, bus (in_*/out_* handshakes).
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int W  = 4,
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  mux_rr_arb_if.slave   bus
);

  logic [SW-1:0] w_arb_idx;
  logic          w_arb_v;
  logic          w_sel_v;
  logic          w_rr;
  logic [SW-1:0] w_g;
  logic          w_gv;
  logic          w_can_load;
  logic          w_xfer;
  logic [W-1:0]  w_data;

  logic [W-1:0]  r_data;
  logic [SW-1:0] r_src;
  logic          r_valid;

  mux_rr_arb_rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.in_valid),
    .advance (w_xfer),
    .en      (w_rr),
    .gnt_idx (w_arb_idx),
    .gnt_v   (w_arb_v)
  );

  assign w_rr       = (mode == MODE_RR);
  assign w_g        = w_rr ? w_arb_idx : sel;
  assign w_gv       = w_rr ? w_arb_v : w_sel_v;
  assign w_can_load = !r_valid || bus.out_ready;
  assign w_xfer     = !rst && w_gv && w_can_load;

  // sel >= N matches no channel, so nothing is granted
  always_comb begin
    w_sel_v = 1'b0;
    w_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i))
        w_sel_v = bus.in_valid[i];
      if (w_g == SW'(i))
        w_data = bus.in_data[i*W +: W];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++)
      bus.in_ready[i] = w_xfer && (w_g == SW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_src   <= w_g;
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_src   = r_src;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Self-checking bench for mux_rr_arb (N=4 and N=3 instances).
// Directed plan followed by randomized traffic vs a queue-free model.
module tb_mux_rr_arb;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode4, mode3;
  logic [1:0] sel4, sel3;

  always #5 clk = ~clk;

  mux_rr_arb_if #(.W(W), .N(4)) b4 ();
  mux_rr_arb_if #(.W(W), .N(3)) b3 ();

  mux_rr_arb #(.W(W), .N(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .mode (mode4),
    .sel  (sel4),
    .bus  (b4)
  );

  mux_rr_arb #(.W(W), .N(3)) dut3 (
    .clk  (clk),
    .rst  (rst),
    .mode (mode3),
    .sel  (sel3),
    .bus  (b3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference state: output register and priority pointer
  bit m_valid[2];
  int m_data[2];
  int m_src[2];
  int m_ptr[2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fair arbitration: first requester at or after ptr, modulo n
  function automatic void model_grant(
    input int n, input logic [3:0] iv, input logic md,
    input int sl, input int ptr, output int g, output bit gv);
    int c;
    g  = 0;
    gv = 0;
    if (md) begin
      for (int k = 0; k < n; k++) begin
        c = (ptr + k) % n;
        if (!gv && iv[c]) begin
          gv = 1;
          g  = c;
        end
      end
    end else begin
      g  = sl;
      gv = (sl < n) && (iv[sl] == 1'b1);
    end
  endfunction

  task automatic cycle();
    int n, sl, g;
    bit gv, can;
    logic [3:0] iv, rdy, exp;
    logic [15:0] idat;
    logic md, ordy;
    bit xf[2];
    bit mds[2];
    bit ords[2];
    int gg[2];
    int dd[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        iv = b4.in_valid; idat = b4.in_data; md = mode4;
        sl = int'(sel4); ordy = b4.out_ready;
        rdy = b4.in_ready; n = 4;
      end else begin
        iv = {1'b0, b3.in_valid}; idat = {4'h0, b3.in_data};
        md = mode3; sl = int'(sel3); ordy = b3.out_ready;
        rdy = {1'b0, b3.in_ready}; n = 3;
      end
      model_grant(n, iv, md, sl, m_ptr[d], g, gv);
      can = !m_valid[d] || ordy;
      exp = (!rst && gv && can) ? 4'(1 << g) : 4'b0;
      chk($sformatf("in_ready[dut%0d]", n), 32'(rdy), 32'(exp));
      xf[d]   = !rst && gv && can;
      gg[d]   = g;
      dd[d]   = int'((idat >> (g * W)) & 16'hf);
      mds[d]  = md;
      ords[d] = ordy;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 4 : 3;
      if (rst) begin
        m_valid[d] = 0; m_data[d] = 0;
        m_src[d] = 0; m_ptr[d] = 0;
      end else if (xf[d]) begin
        m_valid[d] = 1; m_data[d] = dd[d]; m_src[d] = gg[d];
        if (mds[d]) m_ptr[d] = (gg[d] + 1) % n;
      end else if (m_valid[d] && ords[d]) begin
        m_valid[d] = 0;
      end
    end
    chk("out_valid4", 32'(b4.out_valid), 32'(m_valid[0]));
    chk("out_data4", 32'(b4.out_data), 32'(m_data[0]));
    chk("out_src4", 32'(b4.out_src), 32'(m_src[0]));
    chk("out_valid3", 32'(b3.out_valid), 32'(m_valid[1]));
    chk("out_data3", 32'(b3.out_data), 32'(m_data[1]));
    chk("out_src3", 32'(b3.out_src), 32'(m_src[1]));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_data[d] = 0; m_src[d] = 0; m_ptr[d] = 0;
    end
    rst = 1'b1; mode4 = 1'b1; mode3 = 1'b0;
    sel4 = 2'd0; sel3 = 2'd0;
    b4.in_data = 16'h8421; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
    b3.in_data = 12'h421;  b3.in_valid = 3'b000;  b3.out_ready = 1'b1;

    // reset with all channels requesting
    cycle();
    cycle();
    chk("rst_valid", 32'(b4.out_valid), 32'd0);
    chk("rst_data", 32'(b4.out_data), 32'd0);
    chk("rst_src", 32'(b4.out_src), 32'd0);
    chk("rst_ready", 32'(b4.in_ready), 32'd0);
    rst = 1'b0;

    // round-robin fairness, first grant is channel 0
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_src", 32'(b4.out_src), 32'(i % 4));
    end

    // direct-select sweep
    mode4 = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      cycle();
      chk("sel_data", 32'(b4.out_data), 32'(1 << s));
      chk("sel_src", 32'(b4.out_src), 32'(s));
    end

    // sparse RR with wrap: ch2 moves ptr to 3
    mode4 = 1'b1;
    b4.in_valid = 4'b0100;
    cycle();
    b4.in_valid = 4'b0011;
    cycle();
    chk("wrap0", 32'(b4.out_src), 32'd0);
    cycle();
    chk("wrap1", 32'(b4.out_src), 32'd1);
    cycle();
    chk("wrap2", 32'(b4.out_src), 32'd0);

    // back-pressure holding 4'h4
    mode4 = 1'b0; sel4 = 2'd2; b4.in_valid = 4'b1111;
    cycle();
    b4.out_ready = 1'b0; sel4 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_data", 32'(b4.out_data), 32'h4);
      chk("stall_ready", 32'(b4.in_ready), 32'd0);
    end
    b4.out_ready = 1'b1;
    cycle();
    chk("unstall_data", 32'(b4.out_data), 32'h8);
    chk("unstall_valid", 32'(b4.out_valid), 32'd1);

    // N=3: sel=3 selects nothing and lets the register drain
    b3.in_valid = 3'b111; sel3 = 2'd2;
    cycle();
    chk("n3_load", 32'(b3.out_data), 32'h4);
    sel3 = 2'd3;
    cycle();
    chk("n3_sel3_ready", 32'(b3.in_ready), 32'd0);
    chk("n3_sel3_valid", 32'(b3.out_valid), 32'd0);

    // reset while holding a word
    sel4 = 2'd1;
    cycle();
    chk("pre_rst_valid", 32'(b4.out_valid), 32'd1);
    rst = 1'b1;
    cycle();
    chk("mid_rst_valid", 32'(b4.out_valid), 32'd0);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      mode4 = 1'($urandom); mode3 = 1'($urandom);
      sel4 = 2'($urandom); sel3 = 2'($urandom);
      b4.in_data = 16'($urandom); b3.in_data = 12'($urandom);
      b4.in_valid = 4'($urandom); b3.in_valid = 3'($urandom);
      b4.out_ready = ($urandom_range(0, 3) != 0);
      b3.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
